// File: rtl/uart_operand_assembler.sv
// Assembles two little-endian OP_WIDTH-bit operands from a UART byte stream
// and holds them under a valid/ready handshake for the adder stage.
module uart_operand_assembler #(
  parameter int unsigned OP_WIDTH       = 64,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [7:0]          rx_data_i,
  input  logic                rx_valid_i,
  output logic [OP_WIDTH-1:0] birinci_o,
  output logic [OP_WIDTH-1:0] ikinci_o,
  output logic                anacin_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                timeout_o,
  output logic                overrun_o
);

  localparam int unsigned NUM_BYTES = OP_WIDTH / 8;
  localparam int unsigned IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int unsigned CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    COLLECT_A = 2'd0,
    COLLECT_B = 2'd1,
    HOLD      = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_a_c, wr_b_c, timeout_c, overrun_c;

  assign anacin_o = 1'b0;

  // State, byte index and inter-byte idle counter
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= COLLECT_A;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: byte acceptance, frame timeout and HOLD handshake
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    wr_a_c    = 1'b0;
    wr_b_c    = 1'b0;
    timeout_c = 1'b0;
    overrun_c = 1'b0;
    unique case (state_q)
      COLLECT_A, COLLECT_B: begin
        if (rx_valid_i) begin
          wr_a_c = (state_q == COLLECT_A);
          wr_b_c = (state_q == COLLECT_B);
          cnt_d  = '0;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = (state_q == COLLECT_A) ? COLLECT_B : HOLD;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (TIMEOUT_CYCLES != 0 && (state_q == COLLECT_B || idx_q != '0)) begin
          // Only a partial frame ages; an empty COLLECT_A keeps the counter at 0
          if (cnt_q == CNT_LAST) begin
            state_d   = COLLECT_A;
            idx_d     = '0;
            cnt_d     = '0;
            timeout_c = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        cnt_d = '0;
        if (ready_i) begin
          state_d = COLLECT_A;
          idx_d   = '0;
          // A byte coinciding with the handshake starts the next frame
          if (rx_valid_i) begin
            wr_a_c = 1'b1;
            if (LAST_IDX == '0) begin
              state_d = COLLECT_B;
            end else begin
              idx_d = IDX_W'(1);
            end
          end
        end else if (rx_valid_i) begin
          overrun_c = 1'b1;
        end
      end
      default: begin
        state_d = COLLECT_A;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Operand registers and status outputs; idx_q is 0 in HOLD
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      birinci_o <= '0;
      ikinci_o  <= '0;
      valid_o   <= 1'b0;
      timeout_o <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      if (wr_a_c) birinci_o[{idx_q, 3'b000} +: 8] <= rx_data_i;
      if (wr_b_c) ikinci_o[{idx_q, 3'b000} +: 8]  <= rx_data_i;
      valid_o   <= (state_d == HOLD);
      timeout_o <= timeout_c;
      overrun_o <= overrun_c;
    end
  end

endmodule

// File: tb/tb_uart_operand_assembler.sv
// Directed self-checking bench for uart_operand_assembler with a 20-cycle timeout.
module tb_uart_operand_assembler;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [63:0] birinci;
  logic [63:0] ikinci;
  logic        anacin;
  logic        valid;
  logic        ready;
  logic        timeout;
  logic        overrun;

  int checks   = 0;
  int failures = 0;
  int tmo_seen;

  uart_operand_assembler #(.OP_WIDTH(64), .TIMEOUT_CYCLES(20)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .birinci_o  (birinci),
    .ikinci_o   (ikinci),
    .anacin_o   (anacin),
    .valid_o    (valid),
    .ready_i    (ready),
    .timeout_o  (timeout),
    .overrun_o  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (timeout) tmo_seen++;
    end
  endtask

  task automatic handshake();
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; ready = 1'b0;
    tick();
    tick();
    check("rst_birinci", birinci, 64'h0);
    check("rst_ikinci", ikinci, 64'h0);
    check("rst_valid", {63'b0, valid}, 64'h0);
    check("rst_timeout", {63'b0, timeout}, 64'h0);
    check("rst_overrun", {63'b0, overrun}, 64'h0);
    rst_n = 1'b1;
    tick();

    // Back-to-back frame 0x01..0x10
    for (int i = 1; i <= 15; i++) send(8'(i));
    check("t1_valid_before_last", {63'b0, valid}, 64'h0);
    send(8'h10);
    check("t1_valid", {63'b0, valid}, 64'h1);
    check("t1_birinci", birinci, 64'h0807060504030201);
    check("t1_ikinci", ikinci, 64'h100F0E0D0C0B0A09);
    check("t1_anacin", {63'b0, anacin}, 64'h0);

    // Overrun in HOLD, then release
    send(8'hAA);
    check("t2_overrun_pulse", {63'b0, overrun}, 64'h1);
    check("t2_birinci_held", birinci, 64'h0807060504030201);
    check("t2_ikinci_held", ikinci, 64'h100F0E0D0C0B0A09);
    tick();
    check("t2_overrun_clear", {63'b0, overrun}, 64'h0);
    check("t2_valid_still", {63'b0, valid}, 64'h1);
    handshake();
    check("t2_valid_after_hs", {63'b0, valid}, 64'h0);

    // Handshake coinciding with a byte
    for (int i = 0; i < 16; i++) send(8'h33);
    check("t3_valid_pre", {63'b0, valid}, 64'h1);
    ready = 1'b1;
    send(8'h55);
    ready = 1'b0;
    check("t3_valid_after_hs", {63'b0, valid}, 64'h0);
    check("t3_no_overrun", {63'b0, overrun}, 64'h0);
    for (int i = 0; i < 15; i++) send(8'h00);
    check("t3_valid", {63'b0, valid}, 64'h1);
    check("t3_birinci", birinci, 64'h0000000000000055);
    check("t3_ikinci", ikinci, 64'h0);
    handshake();

    // Timeout after 20 idle cycles on a partial frame
    for (int i = 0; i < 5; i++) send(8'hC0 + 8'(i));
    tmo_seen = 0;
    idle(19);
    check("t4_no_early_timeout", 64'(tmo_seen), 64'h0);
    tick();
    check("t4_timeout_pulse", {63'b0, timeout}, 64'h1);
    tick();
    check("t4_timeout_single", {63'b0, timeout}, 64'h0);
    check("t4_birinci_kept", birinci, 64'h000000C4C3C2C1C0);
    tmo_seen = 0;
    idle(30);
    check("t4_idle_empty_no_timeout", 64'(tmo_seen), 64'h0);
    for (int i = 0; i < 16; i++) send(8'hFF);
    check("t4_valid", {63'b0, valid}, 64'h1);
    check("t4_birinci", birinci, 64'hFFFFFFFFFFFFFFFF);
    check("t4_ikinci", ikinci, 64'hFFFFFFFFFFFFFFFF);
    handshake();

    // Byte arriving on the expiry cycle wins
    send(8'h10); send(8'h20); send(8'h30);
    tmo_seen = 0;
    idle(19);
    send(8'h40);
    if (timeout) tmo_seen++;
    tick();
    if (timeout) tmo_seen++;
    check("t5_no_timeout", 64'(tmo_seen), 64'h0);
    send(8'h50); send(8'h60); send(8'h70); send(8'h80);
    check("t5_birinci", birinci, 64'h8070605040302010);
    check("t5_valid_in_b", {63'b0, valid}, 64'h0);
    for (int i = 0; i < 8; i++) send(8'hB0 + 8'(i));
    check("t5_valid", {63'b0, valid}, 64'h1);
    check("t5_ikinci", ikinci, 64'hB7B6B5B4B3B2B1B0);
    handshake();

    // Reset mid-frame in COLLECT_B at index 4
    for (int i = 0; i < 8; i++) send(8'h11);
    for (int i = 0; i < 4; i++) send(8'h22);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6_birinci", birinci, 64'h0);
    check("t6_ikinci", ikinci, 64'h0);
    check("t6_valid", {63'b0, valid}, 64'h0);
    check("t6_timeout", {63'b0, timeout}, 64'h0);
    check("t6_overrun", {63'b0, overrun}, 64'h0);
    for (int i = 0; i < 15; i++) send(8'hA0 + 8'(i));
    check("t6_valid_before_last", {63'b0, valid}, 64'h0);
    send(8'hAF);
    check("t6_valid_fresh", {63'b0, valid}, 64'h1);
    check("t6_birinci_fresh", birinci, 64'hA7A6A5A4A3A2A1A0);
    check("t6_ikinci_fresh", ikinci, 64'hAFAEADACABAAA9A8);
    handshake();
    check("t6_valid_release", {63'b0, valid}, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
